// File: rtl/bresenham_pkg.sv
// Shared types and constants for the Bresenham line engine.
package bresenham_pkg;

    // Default coordinate width; the controller uses the same value.
    localparam int DEFAULT_COORD_W = 8;

    // Error-term width: the doubled error spans roughly +/-4 * 2^COORD_W.
    localparam int DEFAULT_ERR_W = DEFAULT_COORD_W + 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PLOT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_REARM = 3'd4
    } engine_state_t;

    // Signed error term at the default coordinate width.
    typedef logic signed [DEFAULT_ERR_W-1:0] err_t;

endpackage

// File: rtl/bresenham_line_engine_step.sv
// One Bresenham step: next (x, y, err) from the current point and line deltas.
// dx is the positive x span and dy the negated y span.
// sx/sy are direction bits: 1 steps up (+1), 0 steps down (-1).
module bresenham_step
    import bresenham_pkg::*;
#(
    parameter int COORD_W = DEFAULT_COORD_W,
    parameter int ERR_W   = COORD_W + 3
) (
    input  logic [COORD_W-1:0]      x,
    input  logic [COORD_W-1:0]      y,
    input  logic signed [ERR_W-1:0] err,
    input  logic signed [ERR_W-1:0] dx,
    input  logic signed [ERR_W-1:0] dy,
    input  logic                    sx,
    input  logic                    sy,
    output logic [COORD_W-1:0]      x_next,
    output logic [COORD_W-1:0]      y_next,
    output logic signed [ERR_W-1:0] err_next
);

    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    logic signed [ERR_W:0] e2;
    logic signed [ERR_W:0] dx_w;
    logic signed [ERR_W:0] dy_w;
    logic                  step_x;
    logic                  step_y;

    // Both decisions use the pre-step doubled error and accumulate together.
    always_comb begin
        e2       = $signed({err, 1'b0});
        dx_w     = $signed({dx[ERR_W-1], dx});
        dy_w     = $signed({dy[ERR_W-1], dy});
        step_x   = (e2 >= dy_w);
        step_y   = (e2 <= dx_w);
        x_next   = x;
        y_next   = y;
        err_next = err + (step_x ? dy : '0) + (step_y ? dx : '0);
        if (step_x) begin
            x_next = sx ? (x + ONE) : (x - ONE);
        end
        if (step_y) begin
            y_next = sy ? (y + ONE) : (y - ONE);
        end
    end

endmodule

// File: rtl/bresenham_line_engine.sv
// Line rasteriser: accepts a line request and streams one pixel per
// accepted handshake, pulsing draw_done after the final pixel.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for draw_en
// ST_LOAD  | latch endpoints, compute deltas, directions, initial error
// ST_PLOT  | present current pixel, step on handshake
// ST_DONE  | one-cycle draw_done pulse
// ST_REARM | wait for draw_en to drop so a held request is not redrawn
module bresenham_line_engine
    import bresenham_pkg::*;
#(
    parameter int COORD_W = DEFAULT_COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               draw_en,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               pixel_ready,
    output logic               pixel_valid,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               draw_done,
    output logic               busy
);

    localparam int ERR_W = COORD_W + 3;

    engine_state_t state;
    engine_state_t state_next;

    logic [COORD_W-1:0]      cur_x;
    logic [COORD_W-1:0]      cur_y;
    logic [COORD_W-1:0]      end_x;
    logic [COORD_W-1:0]      end_y;
    logic signed [ERR_W-1:0] err;
    logic signed [ERR_W-1:0] dx;
    logic signed [ERR_W-1:0] dy;
    logic                    sx;
    logic                    sy;

    logic [COORD_W:0]        adx;
    logic [COORD_W:0]        ady;
    logic signed [ERR_W-1:0] dx_load;
    logic signed [ERR_W-1:0] dy_load;
    logic signed [ERR_W-1:0] err_load;

    logic [COORD_W-1:0]      step_x;
    logic [COORD_W-1:0]      step_y;
    logic signed [ERR_W-1:0] step_err;

    logic                    at_end;
    logic                    handshake;

    // Line set-up values derived from the live endpoints; registered in LOAD.
    always_comb begin
        adx      = (x1 >= x0) ? ({1'b0, x1} - {1'b0, x0}) : ({1'b0, x0} - {1'b0, x1});
        ady      = (y1 >= y0) ? ({1'b0, y1} - {1'b0, y0}) : ({1'b0, y0} - {1'b0, y1});
        dx_load  = $signed({2'b00, adx});
        dy_load  = -$signed({2'b00, ady});
        err_load = dx_load + dy_load;
    end

    bresenham_step #(
        .COORD_W (COORD_W),
        .ERR_W   (ERR_W)
    ) u_step (
        .x        (cur_x),
        .y        (cur_y),
        .err      (err),
        .dx       (dx),
        .dy       (dy),
        .sx       (sx),
        .sy       (sy),
        .x_next   (step_x),
        .y_next   (step_y),
        .err_next (step_err)
    );

    assign at_end    = (cur_x == end_x) && (cur_y == end_y);
    assign handshake = (state == ST_PLOT) && pixel_ready;

    // Next-state decode; the final handshake wins over a simultaneous abort.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (draw_en) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                state_next = draw_en ? ST_PLOT : ST_IDLE;
            end
            ST_PLOT: begin
                if (pixel_ready && at_end) begin
                    state_next = ST_DONE;
                end else if (!draw_en) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_next = ST_REARM;
            end
            ST_REARM: begin
                if (!draw_en) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register and datapath: latch line in LOAD, advance on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cur_x <= '0;
            cur_y <= '0;
            end_x <= '0;
            end_y <= '0;
            err   <= '0;
            dx    <= '0;
            dy    <= '0;
            sx    <= 1'b0;
            sy    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_LOAD) begin
                cur_x <= x0;
                cur_y <= y0;
                end_x <= x1;
                end_y <= y1;
                dx    <= dx_load;
                dy    <= dy_load;
                err   <= err_load;
                sx    <= (x0 < x1);
                sy    <= (y0 < y1);
            end else if (handshake && !at_end) begin
                cur_x <= step_x;
                cur_y <= step_y;
                err   <= step_err;
            end
        end
    end

    assign pixel_valid = (state == ST_PLOT);
    assign pixel_x     = cur_x;
    assign pixel_y     = cur_y;
    assign draw_done   = (state == ST_DONE);
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Self-checking bench for bresenham_line_engine: directed lines from the
// test plan plus random lines with random back-pressure, compared against
// an integer reference rasteriser.
module tb_bresenham_line_engine;

    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          draw_en;
    logic [CW-1:0] x0, y0, x1, y1;
    logic          pixel_ready;
    logic          pixel_valid;
    logic [CW-1:0] pixel_x, pixel_y;
    logic          draw_done;
    logic          busy;

    int vectors;
    int miscompares;
    int exp_x[$];
    int exp_y[$];

    bresenham_line_engine #(.COORD_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .draw_en     (draw_en),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .pixel_ready (pixel_ready),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .draw_done   (draw_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int expv);
        vectors++;
        if (got != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference rasteriser on plain integers; fills exp_x/exp_y.
    task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1);
        int x, y, ddx, ddy, sx, sy, err, e2;
        exp_x.delete();
        exp_y.delete();
        x   = ax0;
        y   = ay0;
        ddx = iabs(ax1 - ax0);
        ddy = -iabs(ay1 - ay0);
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = ddx + ddy;
        for (int guard = 0; guard < 1000; guard++) begin
            exp_x.push_back(x);
            exp_y.push_back(y);
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= ddy) begin err += ddy; x += sx; end
            if (e2 <= ddx) begin err += ddx; y += sy; end
        end
    endtask

    // Drive one full line and check every pixel, latency, stall stability,
    // the done pulse, and (optionally) that a held request is not redrawn.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int rdy_pct, input int stall_idx, input int stall_len,
                            input int hold);
        int  n_rule, hs, cyc, last_hs, done_cnt, stall_left, px, py;
        bit  seen_valid, prev_stall, finished;
        model_line(ax0, ay0, ax1, ay1);
        n_rule     = ((iabs(ax1 - ax0) > iabs(ay1 - ay0)) ? iabs(ax1 - ax0) : iabs(ay1 - ay0)) + 1;
        hs         = 0;
        cyc        = 0;
        last_hs    = -10;
        done_cnt   = 0;
        stall_left = stall_len;
        seen_valid = 1'b0;
        prev_stall = 1'b0;
        finished   = 1'b0;
        px         = 0;
        py         = 0;
        @(negedge clk);
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        draw_en     = 1'b1;
        pixel_ready = 1'b0;
        while (!finished && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (draw_done) begin
                done_cnt++;
                chk("done_after_last_hs", cyc, last_hs + 1);
                chk("pixels_left_at_done", exp_x.size(), 0);
                finished = 1'b1;
                if (hold == 0) draw_en = 1'b0;
            end else if (pixel_valid) begin
                if (!seen_valid) begin
                    chk("first_pixel_latency", cyc, 2);
                    seen_valid = 1'b1;
                end
                if (prev_stall) begin
                    chk("stall_x_stable", int'(pixel_x), px);
                    chk("stall_y_stable", int'(pixel_y), py);
                end
                if (stall_left > 0 && hs == stall_idx) begin
                    pixel_ready = 1'b0;
                    stall_left--;
                end else begin
                    pixel_ready = ($urandom_range(99) < rdy_pct);
                end
                if (pixel_ready) begin
                    if (exp_x.size() == 0) begin
                        chk("pixel_overrun", hs + 1, n_rule);
                    end else begin
                        chk("pixel_x", int'(pixel_x), exp_x.pop_front());
                        chk("pixel_y", int'(pixel_y), exp_y.pop_front());
                    end
                    hs++;
                    last_hs    = cyc;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    px = int'(pixel_x);
                    py = int'(pixel_y);
                end
            end else begin
                pixel_ready = $urandom_range(1) == 1;
            end
        end
        chk("done_seen", done_cnt, 1);
        chk("handshakes", hs, n_rule);
        pixel_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("held_no_valid", int'(pixel_valid), 0);
            chk("held_no_done", int'(draw_done), 0);
            chk("held_busy", int'(busy), 1);
        end
        draw_en = 1'b0;
        @(negedge clk);
        chk("no_second_done", int'(draw_done), 0);
        @(negedge clk);
        chk("idle_after_line", int'(busy), 0);
    endtask

    // Start (0,0)->(9,9), abort after the 2nd pixel via rst or draw_en drop.
    task automatic abort_test(input bit use_rst);
        int hs, cyc;
        hs  = 0;
        cyc = 0;
        @(negedge clk);
        x0 = 0; y0 = 0; x1 = 9; y1 = 9;
        draw_en     = 1'b1;
        pixel_ready = 1'b1;
        while (hs < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (pixel_valid && pixel_ready) begin
                chk("abort_pix_x", int'(pixel_x), hs);
                chk("abort_pix_y", int'(pixel_y), hs);
                hs++;
            end
        end
        chk("abort_reached_2nd", hs, 2);
        if (use_rst) rst = 1'b1;
        else         draw_en = 1'b0;
        @(negedge clk);
        chk("abort_valid", int'(pixel_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(draw_done), 0);
        if (use_rst) begin
            chk("rst_pixel_x", int'(pixel_x), 0);
            chk("rst_pixel_y", int'(pixel_y), 0);
        end
        rst         = 1'b0;
        draw_en     = 1'b0;
        pixel_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_abort_valid", int'(pixel_valid), 0);
            chk("post_abort_done", int'(draw_done), 0);
        end
    endtask

    initial begin
        int rx0, ry0, rx1, ry1, lim;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        draw_en     = 1'b0;
        pixel_ready = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid", int'(pixel_valid), 0);
        chk("reset_done", int'(draw_done), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pixel_x", int'(pixel_x), 0);
        chk("reset_pixel_y", int'(pixel_y), 0);
        rst = 1'b0;
        @(negedge clk);

        run_line(0, 0, 3, 0, 100, -1, 0, 0);
        run_line(3, 3, 0, 0, 100, -1, 0, 0);
        run_line(0, 0, 2, 1, 100, 1, 3, 0);
        run_line(7, 7, 7, 7, 100, -1, 0, 0);
        run_line(0, 0, 3, 0, 100, -1, 0, 5);
        run_line(10, 0, 10, 2, 100, -1, 0, 0);
        abort_test(1'b1);
        abort_test(1'b0);
        run_line(255, 0, 0, 255, 100, -1, 0, 0);
        run_line(0, 200, 255, 190, 80, -1, 0, 0);

        for (int n = 0; n < 24; n++) begin
            lim = (n % 4 == 0) ? 255 : 40;
            rx0 = $urandom_range(lim);
            ry0 = $urandom_range(lim);
            rx1 = $urandom_range(lim);
            ry1 = $urandom_range(lim);
            run_line(rx0, ry0, rx1, ry1, (n % 3 == 0) ? 100 : 60, -1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
